// File: rtl/park_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : park_disp_sched
//  Purpose  : Parking-lot occupancy controller with a multiplexed display.
//             It detects entry and exit sensor edges, keeps the free-space
//             count in 2-digit BCD, and drives one shared hex-to-7-segment
//             decoder across 4 digit positions:
//               slot 0 = ones, slot 1 = tens,
//               slot 2 = status (F full / A not full), slot 3 = event code.
//  Options  : PARK_DISP_BLANK_GUARD_EN - when this macro is defined, every
//             digit switch is preceded by one blank cycle (digit_en = 0).
//  Revision : 1.0 - initial release
// ============================================================================
module park_disp_sched #(
  parameter int CAPACITY    = 20,
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       car_in,
  input  logic       car_out,
  output logic [3:0] nib_out,
  output logic [3:0] digit_en,
  output logic [7:0] free_bcd,
  output logic       full,
  output logic       empty
);

  localparam int              DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [7:0]      CAP_BCD  = {4'(CAPACITY / 10), 4'(CAPACITY % 10)};

  localparam logic [3:0] EVT_NONE = 4'h0;
  localparam logic [3:0] EVT_IN   = 4'h1;
  localparam logic [3:0] EVT_OUT  = 4'h2;
  localparam logic [3:0] EVT_BOTH = 4'hC;
  localparam logic [3:0] EVT_REJ  = 4'hE;

  localparam logic [3:0] STAT_FULL = 4'hF;
  localparam logic [3:0] STAT_AVL  = 4'hA;

  logic             car_in_q, car_out_q;
  logic [7:0]       free_q, free_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [3:0]       evt_q, evt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       nib_q, nib_d;
  logic [3:0]       den_q, den_d;
  logic             in_ev, out_ev, tick;
`ifdef PARK_DISP_BLANK_GUARD_EN
  logic             guard_q, guard_d;
`endif

  // BCD decrement: borrow from tens when the ones digit is zero.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  // BCD increment: carry into tens when the ones digit is nine.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Occupancy update: sensor edges adjust the count and record an event code.
  always_comb begin
    in_ev  = car_in  & ~car_in_q;
    out_ev = car_out & ~car_out_q;
    free_d = free_q;
    evt_d  = evt_q;
    case ({in_ev, out_ev})
      2'b10: begin
        if (free_q != 8'h00) begin
          free_d = bcd_dec(free_q);
          evt_d  = EVT_IN;
        end else begin
          evt_d  = EVT_REJ;
        end
      end
      2'b01: begin
        if (free_q != CAP_BCD) begin
          free_d = bcd_inc(free_q);
          evt_d  = EVT_OUT;
        end else begin
          evt_d  = EVT_REJ;
        end
      end
      2'b11:   evt_d = EVT_BOTH;
      default: evt_d = evt_q;
    endcase
    full_d  = (free_d == 8'h00);
    empty_d = (free_d == CAP_BCD);
  end

  // Scanner: divider wrap advances the slot; the display reloads every cycle
  // from the current slot so count changes show without waiting for a tick.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_ONE;
    idx_d = tick ? idx_q + 2'd1 : idx_q;
    case (idx_q)
      2'd0:    nib_d = free_q[3:0];
      2'd1:    nib_d = free_q[7:4];
      2'd2:    nib_d = full_q ? STAT_FULL : STAT_AVL;
      default: nib_d = evt_q;
    endcase
    den_d = 4'b0001 << idx_q;
`ifdef PARK_DISP_BLANK_GUARD_EN
    // The nibble changes first; the enable follows one cycle later.
    guard_d = tick;
    if (guard_q) den_d = 4'b0000;
`endif
  end

  // State register with synchronous reset; sensor history clears too so a
  // level still high after reset is seen as a fresh edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      car_in_q  <= 1'b0;
      car_out_q <= 1'b0;
      free_q    <= CAP_BCD;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      evt_q     <= EVT_NONE;
      div_q     <= '0;
      idx_q     <= 2'd0;
      nib_q     <= 4'h0;
      den_q     <= 4'b0000;
`ifdef PARK_DISP_BLANK_GUARD_EN
      guard_q   <= 1'b0;
`endif
    end else begin
      car_in_q  <= car_in;
      car_out_q <= car_out;
      free_q    <= free_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      evt_q     <= evt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      nib_q     <= nib_d;
      den_q     <= den_d;
`ifdef PARK_DISP_BLANK_GUARD_EN
      guard_q   <= guard_d;
`endif
    end
  end

  assign nib_out  = nib_q;
  assign digit_en = den_q;
  assign free_bcd = free_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_park_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_park_disp_sched
//  Purpose  : Self-checking bench for park_disp_sched (CAPACITY 20,
//             REFRESH_DIV 4). Expected count/flags are produced by a
//             behavioural model, queued when stimulus is applied and popped
//             when the DUT result is sampled on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_park_disp_sched;

  localparam int CAP = 20;
  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       car_in = 1'b0;
  logic       car_out = 1'b0;
  logic [3:0] nib_out;
  logic [3:0] digit_en;
  logic [7:0] free_bcd;
  logic       full;
  logic       empty;

  park_disp_sched #(.CAPACITY(CAP), .REFRESH_DIV(DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .car_in   (car_in),
    .car_out  (car_out),
    .nib_out  (nib_out),
    .digit_en (digit_en),
    .free_bcd (free_bcd),
    .full     (full),
    .empty    (empty)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] bcd;
    logic       full;
    logic       empty;
  } exp_t;

  exp_t sb[$];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_free   = CAP;
  logic [3:0] m_evt    = 4'h0;
  logic       prev_ci  = 1'b0;
  logic       prev_co  = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int f);
    return {4'(f / 10), 4'(f % 10)};
  endfunction

  task automatic model_reset();
    m_free  = CAP;
    m_evt   = 4'h0;
    prev_ci = 1'b0;
    prev_co = 1'b0;
  endtask

  // Apply one cycle of sensor levels, predict, then compare after the edge.
  task automatic step(input logic ci, input logic co);
    logic iev, oev;
    exp_t e;
    iev = ci & ~prev_ci;
    oev = co & ~prev_co;
    if (iev && oev) m_evt = 4'hC;
    else if (iev) begin
      if (m_free > 0) begin m_free--; m_evt = 4'h1; end
      else m_evt = 4'hE;
    end else if (oev) begin
      if (m_free < CAP) begin m_free++; m_evt = 4'h2; end
      else m_evt = 4'hE;
    end
    e.bcd   = to_bcd(m_free);
    e.full  = (m_free == 0);
    e.empty = (m_free == CAP);
    sb.push_back(e);
    car_in  = ci;
    car_out = co;
    prev_ci = ci;
    prev_co = co;
    @(negedge clock);
    e = sb.pop_front();
    chk("free_bcd", free_bcd, e.bcd);
    chk("full", 8'(full), 8'(e.full));
    chk("empty", 8'(empty), 8'(e.empty));
  endtask

  // Wait (bounded) for a slot to be enabled, then check its nibble.
  task automatic check_slot(input int idx, input logic [3:0] exp);
    logic       found;
    logic [3:0] oh;
    found = 1'b0;
    oh    = 4'(1 << idx);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (digit_en == oh) found = 1'b1;
    end
    if (found) chk($sformatf("slot%0d_nib", idx), 8'(nib_out), 8'(exp));
    else       chk($sformatf("slot%0d_timeout", idx), 8'h00, 8'h01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] scan_nib [4];
    logic [3:0] den_exp;
    logic       found;
    int         slot;
    scan_nib = '{4'h0, 4'h2, 4'hA, 4'h0};

    // Reset state.
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_free", free_bcd, 8'h20);
    chk("rst_empty", 8'(empty), 8'h01);
    chk("rst_full", 8'(full), 8'h00);
    chk("rst_den", 8'(digit_en), 8'h00);
    chk("rst_nib", 8'(nib_out), 8'h00);

    // Scan sequence over one full rotation after release.
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      slot    = k / DIV;
      den_exp = 4'(1 << slot);
`ifdef PARK_DISP_BLANK_GUARD_EN
      if ((k % DIV) == 0 && k != 0) den_exp = 4'b0000;
`endif
      chk($sformatf("scan_den_%0d", k), 8'(digit_en), 8'(den_exp));
      chk($sformatf("scan_nib_%0d", k), 8'(nib_out), 8'(scan_nib[slot]));
    end

    // 20 arrivals fill the lot.
    for (int p = 0; p < 20; p++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    check_slot(2, 4'hF);
    check_slot(3, m_evt);

    // 21st arrival is rejected.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_slot(3, 4'hE);

    // Simultaneous arrival and departure while full.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_slot(3, 4'hC);

    // Single departure.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_slot(3, 4'h2);
    check_slot(2, 4'hA);

    // Drain back to empty, then a rejected departure.
    for (int p = 0; p < 19; p++) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_slot(3, 4'hE);

    // Held entry level counts once.
    for (int p = 0; p < 10; p++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("held_once", free_bcd, 8'h19);

    // Down to 07, then reset in the middle of slot 2.
    for (int p = 0; p < 12; p++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("at_07", free_bcd, 8'h07);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (digit_en == 4'b0100) found = 1'b1;
    end
    if (!found) chk("slot2_wait_timeout", 8'h00, 8'h01);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_free", free_bcd, 8'h20);
    chk("midrst_den", 8'(digit_en), 8'h00);
    chk("midrst_nib", 8'(nib_out), 8'h00);
    chk("midrst_empty", 8'(empty), 8'h01);
    chk("midrst_full", 8'(full), 8'h00);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    chk("post_rst_den", 8'(digit_en), 8'h01);
    chk("post_rst_nib", 8'(nib_out), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/park_disp_sched.md
Name: park_disp_sched

Overview:
- Parking-lot occupancy controller and display scheduler.
- Detects car entry/exit sensor edges and keeps the free-space count in 2-digit BCD.
- Time-multiplexes a single shared hex-to-7-segment decoder across 4 digit positions.
- Drives the decoder's 4-bit nibble input (c3..c0 = nib_out[3:0]) and a one-hot digit enable; the decoder's active-low segment outputs go straight to the display.

Parameters:
- CAPACITY, 20, lot size and reset free count; legal 1..99.
- REFRESH_DIV, 50000, clocks per digit slot; legal >= 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- car_in  input  1  entry sensor level; each rising edge is one arrival.
- car_out  input  1  exit sensor level; each rising edge is one departure.
- nib_out  output  4  nibble to the shared seg7 decoder.
- digit_en  output  4  one-hot digit enable; bit0 = rightmost digit.
- free_bcd  output  8  free spaces in BCD; [7:4] tens, [3:0] ones.
- full  output  1  high when free count is 0.
- empty  output  1  high when free count equals CAPACITY.

Behaviour:
- All outputs are registered.
- Reset values:
  - free_bcd = CAPACITY in BCD (default 8'h20); full = 0; empty = 1.
  - nib_out = 4'h0; digit_en = 4'b0000.
  - scan index = 0; divider = 0; event code = 4'h0; sensor history registers = 0.
- Edge detect:
  - in_ev = car_in & ~car_in_q; out_ev = car_out & ~car_out_q (history registered each cycle).
  - Holding a level high produces exactly one event.
- Count update, applied on the same edge in_ev/out_ev is sampled (1-cycle latency):
  - in_ev only, free > 0: free - 1, event code 4'h1.
  - in_ev only, free = 0: reject; count unchanged, event code 4'hE.
  - out_ev only, free < CAPACITY: free + 1, event code 4'h2.
  - out_ev only, free = CAPACITY: reject; count unchanged, event code 4'hE.
  - in_ev and out_ev together: always accepted, net zero, count unchanged, event code 4'hC.
- BCD arithmetic:
  - Decrement with ones = 0 gives ones = 9, tens - 1.
  - Increment with ones = 9 gives ones = 0, tens + 1.
  - No binary intermediate. Tens never exceeds 9.
- full and empty are recomputed from the updated count, on the same edge.
- Scanner:
  - The divider counts 0..REFRESH_DIV-1 and wraps. The wrap cycle is "tick".
  - On tick, the scan index advances 0 -> 1 -> 2 -> 3 -> 0.
- Slot contents:
  - Slot 0: ones digit.
  - Slot 1: tens digit.
  - Slot 2: status, 4'hF if full, else 4'hA.
  - Slot 3: current event code.
- Every non-guard cycle: nib_out <= slot nibble of the current index; digit_en <= onehot(index).
- The displayed value refreshes every cycle. Count changes appear on the next cycle without waiting for a tick.
- First cycle after reset release: digit_en = 0001, nib_out = ones digit.
- Reset asserted mid-scan or mid-event: all state returns to reset values on that edge. Sensor history also clears, so a level still high after reset counts as a new edge.
- CAPACITY outside 1..99 is unsupported (no checking required).

Optional Feature:
- Macro: PARK_DISP_BLANK_GUARD_EN.
- Defined:
  - In the cycle after each tick, digit_en = 4'b0000 while nib_out already carries the new slot nibble.
  - The new one-hot enable asserts one cycle later.
  - This prevents ghosting on common-anode drivers.
  - The divider keeps running through the guard cycle; slot period is still REFRESH_DIV.
- Undefined: digit_en and nib_out switch together in the cycle after a tick; no blank cycle.

Test Plan:
- Reset, CAPACITY = 20, REFRESH_DIV = 4:
  - free_bcd = 8'h20, empty = 1, full = 0.
  - Scan sequence with digit_en / nib_out: 0001/0, then 0010/2, 0100/A, 1000/0, each held 4 cycles.
- 20 car_in pulses (1 high, 1 low):
  - free_bcd steps 20, 19, ..., 10, 09, ..., 00 (BCD borrow at 20->19 and 10->09).
  - full = 1 at 00; slot 2 shows F.
  - A 21st pulse leaves 00 and sets event code E.
- From full, car_in and car_out rise in the same cycle:
  - free stays 00, event code C.
  - Then car_out alone: free = 01, full = 0, event code 2, slot 2 shows A.
- At free = 20, car_out pulse: rejected, free stays 20, event code E.
- car_in held high 10 cycles: exactly one decrement (20 -> 19).
- Assert reset mid-slot 2 with free = 07: next cycle free_bcd = 20, digit_en = 0000.
  - With PARK_DISP_BLANK_GUARD_EN: check one all-zero digit_en cycle after every tick.
  - Without the macro: check none.
